// File: rtl/order_dispatch_scheduler.sv
// Serializes 4-asset order snapshots onto one valid/ready order channel with a rotating start asset.
// Optional feature macro THROTTLE_EN: forces MIN_GAP idle cycles after every handshake.
module order_dispatch_scheduler #(
  parameter int unsigned N       = 4,
  parameter int unsigned DROP_W  = 8,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Enable,
  input  logic              i_Valid,
  input  logic [15:0]       i_Quantity0,
  input  logic [15:0]       i_Quantity1,
  input  logic [15:0]       i_Quantity2,
  input  logic [15:0]       i_Quantity3,
  input  logic [15:0]       i_BestPrice0,
  input  logic [15:0]       i_BestPrice1,
  input  logic [15:0]       i_BestPrice2,
  input  logic [15:0]       i_BestPrice3,
  input  logic              i_BuySell0,
  input  logic              i_BuySell1,
  input  logic              i_BuySell2,
  input  logic              i_BuySell3,
  input  logic              i_OrderReady,
  output logic              o_OrderValid,
  output logic [1:0]        o_OrderAsset,
  output logic [15:0]       o_OrderQuantity,
  output logic [15:0]       o_OrderPrice,
  output logic              o_OrderSide,
  output logic              o_Busy,
  output logic              o_BatchDone,
  output logic [DROP_W-1:0] o_DropCount
);
  localparam int unsigned GapW = $clog2(MIN_GAP + 2);
`ifdef THROTTLE_EN
  localparam logic [GapW-1:0] Gap = GapW'(MIN_GAP);
`else
  localparam logic [GapW-1:0] Gap = '0;
`endif

  typedef enum logic [1:0] {StIdle, StDispatch, StDone} state_e;

  typedef struct packed {
    logic [N-1:0][15:0] qty;
    logic [N-1:0][15:0] prc;
    logic [N-1:0]       side;
  } snap_t;

  state_e            state_q, state_d;
  snap_t             act_q, act_d, pend_q, pend_d, in_snap;
  logic [N-1:0]      rem_q, rem_d, in_mask, pend_mask, rem_after;
  logic              act_full_q, act_full_d, pend_full_q, pend_full_d;
  logic [1:0]        ptr_q, ptr_d, cur;
  logic [DROP_W-1:0] drop_q;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              cap, order_valid, hs, last, batch_done, cap_used, pend_free, drop_inc;

  function automatic logic [N-1:0] nz_mask(input snap_t s);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (s.qty[i] != '0);
    return m;
  endfunction

  assign in_snap = {i_Quantity3, i_Quantity2, i_Quantity1, i_Quantity0,
                    i_BestPrice3, i_BestPrice2, i_BestPrice1, i_BestPrice0,
                    i_BuySell3, i_BuySell2, i_BuySell1, i_BuySell0};
  assign in_mask   = nz_mask(in_snap);
  assign pend_mask = nz_mask(pend_q);
  assign cap       = i_Valid & i_Enable;

  // First unsent nonzero asset at or after the start pointer, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    cur   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && rem_q[idx]) begin
        cur   = idx;
        found = 1'b1;
      end
    end
  end

  assign order_valid = (state_q == StDispatch) && (gap_q == '0);
  assign hs          = order_valid & i_OrderReady;
  assign rem_after   = rem_q & ~(N'(1) << cur);
  assign last        = hs && (rem_after == '0);
  assign gap_d       = hs ? Gap : ((gap_q != '0) ? gap_q - GapW'(1) : '0);

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    rem_d       = rem_q;
    act_full_d  = act_full_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    ptr_d       = ptr_q;
    batch_done  = 1'b0;
    cap_used    = 1'b0;
    pend_free   = !pend_full_q;
    drop_inc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cap) begin
          act_d    = in_snap;
          rem_d    = in_mask;
          cap_used = 1'b1;
          state_d  = (in_mask != '0) ? StDispatch : StDone;
        end
      end
      StDispatch: begin
        if (hs) begin
          rem_d = rem_after;
          if (last) begin
            state_d = StDone;
            // act_full marks a loaded snapshot that has not started yet
            if (pend_full_q) begin
              act_d       = pend_q;
              rem_d       = pend_mask;
              act_full_d  = 1'b1;
              pend_full_d = 1'b0;
              pend_free   = 1'b1;
            end
          end
        end
      end
      StDone: begin
        batch_done = 1'b1;
        ptr_d      = ptr_q + 2'd1;
        act_full_d = 1'b0;
        if (act_full_q && (rem_q != '0)) begin
          state_d = StDispatch;
        end else begin
          if (pend_full_q) begin
            act_d       = pend_q;
            rem_d       = pend_mask;
            pend_full_d = 1'b0;
            pend_free   = 1'b1;
          end else if (cap) begin
            act_d    = in_snap;
            rem_d    = in_mask;
            cap_used = 1'b1;
          end
          // A loaded all-zero snapshot still owes its own BatchDone pulse.
          if (act_full_q) begin
            state_d    = StDone;
            act_full_d = pend_full_q | cap;
          end else if (pend_full_q || cap) begin
            state_d = (rem_d != '0) ? StDispatch : StDone;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (cap && !cap_used) begin
      if (pend_free) begin
        pend_d      = in_snap;
        pend_full_d = 1'b1;
      end else begin
        drop_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      act_q       <= '0;
      rem_q       <= '0;
      act_full_q  <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      ptr_q       <= '0;
      drop_q      <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      rem_q       <= rem_d;
      act_full_q  <= act_full_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      if (drop_inc && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign o_OrderValid    = order_valid;
  assign o_OrderAsset    = order_valid ? cur : 2'd0;
  assign o_OrderQuantity = order_valid ? act_q.qty[cur] : 16'd0;
  assign o_OrderPrice    = order_valid ? act_q.prc[cur] : 16'd0;
  assign o_OrderSide     = order_valid & act_q.side[cur];
  assign o_Busy          = (state_q != StIdle) | pend_full_q;
  assign o_BatchDone     = batch_done;
  assign o_DropCount     = drop_q;

endmodule

// File: tb/tb_order_dispatch_scheduler.sv
// Bench for order_dispatch_scheduler: directed scenarios plus random traffic against a
// transaction-level model (queue of held snapshots, list of orders still owed by the head).
module tb_order_dispatch_scheduler;
`ifdef THROTTLE_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, vld, rdy;
  logic [15:0] qty [4];
  logic [15:0] prc [4];
  logic        side [4];
  logic        ov, os, busy, done;
  logic [1:0]  oa;
  logic [15:0] oq, op;
  logic [7:0]  drops;

  always #5 clk = ~clk;

  order_dispatch_scheduler #(.N(4), .DROP_W(8), .MIN_GAP(2)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Valid(vld),
    .i_Quantity0(qty[0]), .i_Quantity1(qty[1]), .i_Quantity2(qty[2]), .i_Quantity3(qty[3]),
    .i_BestPrice0(prc[0]), .i_BestPrice1(prc[1]), .i_BestPrice2(prc[2]), .i_BestPrice3(prc[3]),
    .i_BuySell0(side[0]), .i_BuySell1(side[1]), .i_BuySell2(side[2]), .i_BuySell3(side[3]),
    .i_OrderReady(rdy), .o_OrderValid(ov), .o_OrderAsset(oa), .o_OrderQuantity(oq),
    .o_OrderPrice(op), .o_OrderSide(os), .o_Busy(busy), .o_BatchDone(done), .o_DropCount(drops)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  int hs_log[$];
  int exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0][15:0] q;
    logic [3:0][15:0] p;
    logic [3:0]       s;
  } snap_t;

  snap_t m_held[$];
  int    m_todo[$];
  bit    m_live, m_pulse, m_next_pulse;
  int    m_ptr, m_gap, m_drops;

  function automatic snap_t in_snap();
    snap_t s;
    for (int i = 0; i < 4; i++) begin
      s.q[i] = qty[i];
      s.p[i] = prc[i];
      s.s[i] = side[i];
    end
    return s;
  endfunction

  // Head snapshot begins: either an all-zero batch (pulse only) or a list of nonzero assets.
  function automatic void m_start_head();
    if (m_held[0].q == '0) begin
      void'(m_held.pop_front());
      m_next_pulse = 1'b1;
    end else begin
      m_live = 1'b1;
      m_todo.delete();
      for (int k = 0; k < 4; k++)
        if (m_held[0].q[(m_ptr + k) % 4] != 16'd0) m_todo.push_back((m_ptr + k) % 4);
    end
  endfunction

  always @(posedge clk) begin
    bit hs, cap;
    if (rst) begin
      m_held.delete();
      m_todo.delete();
      m_live = 1'b0; m_pulse = 1'b0; m_ptr = 0; m_gap = 0; m_drops = 0;
    end else begin
      hs  = m_live && (m_gap == 0) && rdy;
      cap = vld && en;
      m_next_pulse = 1'b0;
      if (m_gap > 0) m_gap--;
      if (hs) begin
        void'(m_todo.pop_front());
        m_gap = GAP;
        if (m_todo.size() == 0) begin
          void'(m_held.pop_front());
          m_live = 1'b0;
          m_next_pulse = 1'b1;
        end
      end
      if (m_pulse) begin
        m_ptr = (m_ptr + 1) % 4;
        if (m_held.size() != 0) m_start_head();
      end
      if (cap) begin
        if (m_held.size() < 2) begin
          m_held.push_back(in_snap());
          if (!m_live && !m_next_pulse && m_held.size() == 1) m_start_head();
        end else if (m_drops < 255) begin
          m_drops++;
        end
      end
      m_pulse = m_next_pulse;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      bit ev;
      int a;
      ev = m_live && (m_gap == 0);
      chk("m_valid", 64'(ov), 64'(ev));
      if (ev) begin
        a = m_todo[0];
        chk("m_asset", 64'(oa), 64'(a));
        chk("m_qty",   64'(oq), 64'(m_held[0].q[a]));
        chk("m_price", 64'(op), 64'(m_held[0].p[a]));
        chk("m_side",  64'(os), 64'(m_held[0].s[a]));
      end
      chk("m_done",  64'(done),  64'(m_pulse));
      chk("m_busy",  64'(busy),  64'(m_live || m_pulse || (m_held.size() != 0)));
      chk("m_drops", 64'(drops), 64'(m_drops));
      if (ov && rdy && !rst) hs_log.push_back(int'(oa));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int b, input int c, input int d);
    qty[0] = 16'(a); qty[1] = 16'(b); qty[2] = 16'(c); qty[3] = 16'(d);
    for (int i = 0; i < 4; i++) begin
      prc[i]  = 16'($urandom);
      side[i] = 1'($urandom);
    end
    vld = 1'b1;
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_count"}, 64'(hs_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, 64'((i < hs_log.size()) ? hs_log[i] : 99), 64'(exp_q[i]));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {18'd0, ov, oa, oq, op, os, busy, done, drops}, 64'd0);
  endtask

  initial begin
    logic [15:0] vmask, dmask;
    rst = 1'b1; en = 1'b0; vld = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qty[i] = '0; prc[i] = '0; side[i] = 1'b0;
    end
    step(); step();
    chk_on = 1'b1;
    chk_all_zero("reset_state");
    rst = 1'b0;

    // Test 1: Q = {10,0,5,7}, ready tied high.
    rdy = 1'b1; en = 1'b1; hs_log.delete();
    load(10, 0, 5, 7);
    vmask = '0; dmask = '0;
    for (int j = 1; j <= 12; j++) begin
      step();
      vld = 1'b0;
      vmask[j] = ov;
      dmask[j] = done;
    end
`ifndef THROTTLE_EN
    chk("t1_valid_cycles", 64'(vmask), 64'(16'h000E));
    chk("t1_done_cycle",   64'(dmask), 64'(16'h0010));
`endif
    exp_q = '{0, 2, 3};
    chk_order("t1_order");

    // Test 2: rotated start pointer.
    hs_log.delete();
    load(1, 1, 1, 1);
    for (int j = 0; j < 12; j++) begin
      step();
      vld = 1'b0;
    end
    exp_q = '{1, 2, 3, 0};
    chk_order("t2_order");

    // Test 3: stall with ready low; start pointer is now 2.
    rdy = 1'b0;
    load(4, 0, 9, 0);
    prc[2] = 16'hF380; side[2] = 1'b1;
    step();
    vld = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("t3_hold", {29'd0, ov, oa, oq, op, os}, {29'd0, 1'b1, 2'd2, 16'd9, 16'hF380, 1'b1});
      step();
    end
    rdy = 1'b1;
    for (int j = 0; j < 12; j++) step();

    // Test 4: three back-to-back snapshots while stalled.
    rdy = 1'b0; hs_log.delete();
    load(1, 2, 3, 4); step();
    load(5, 6, 7, 8); step();
    load(9, 9, 9, 9); step();
    vld = 1'b0;
    step();
    chk("t4_drops", 64'(drops), 64'd1);
    rdy = 1'b1;
    for (int j = 0; j < 40; j++) step();
    exp_q = '{3, 0, 1, 2, 0, 1, 2, 3};
    chk_order("t4_order");

    // Test 5: all-zero snapshot, then a strobe with enable low.
    hs_log.delete();
    load(0, 0, 0, 0);
    step();
    vld = 1'b0;
    chk("t5_done_t1", 64'(done), 64'd1);
    chk("t5_no_valid", 64'(ov), 64'd0);
    step();
    chk("t5_done_clear", 64'(done), 64'd0);
    en = 1'b0;
    load(5, 5, 5, 5);
    step();
    vld = 1'b0;
    step();
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_no_drop", 64'(drops), 64'd1);
    chk("t5_no_orders", 64'(hs_log.size()), 64'd0);
    en = 1'b1;

`ifdef THROTTLE_EN
    // Test 6: throttled spacing.
    rdy = 1'b1;
    load(3, 3, 3, 3);
    vmask = '0;
    for (int j = 1; j <= 12; j++) begin
      step();
      vld = 1'b0;
      vmask[j] = ov;
    end
    chk("t6_gap_cycles", 64'(vmask), 64'(16'b0000_0100_1001_0010));
    for (int j = 0; j < 8; j++) step();
`endif

    // Reset in the middle of a batch.
    rdy = 1'b0;
    load(3, 3, 3, 3);
    step();
    vld = 1'b0;
    step();
    chk("mid_valid", 64'(ov), 64'd1);
    rst = 1'b1;
    step();
    chk_all_zero("mid_reset");
    rst = 1'b0;

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      en  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 6);
      vld = ($urandom_range(0, 9) < 3);
      for (int i = 0; i < 4; i++) begin
        qty[i]  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        prc[i]  = 16'($urandom);
        side[i] = 1'($urandom);
      end
      step();
    end

    // Saturate the drop counter.
    rst = 1'b1; vld = 1'b0; step(); rst = 1'b0;
    rdy = 1'b0; en = 1'b1;
    for (int c = 0; c < 280; c++) begin
      load($urandom_range(1, 100), $urandom_range(0, 100), $urandom_range(0, 100), 1);
      step();
    end
    vld = 1'b0;
    chk("drop_saturate", 64'(drops), 64'd255);
    rdy = 1'b1;
    for (int j = 0; j < 40; j++) step();
    chk("drain_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
